rect_corner_capture: RTL

- Upstream feeder for the rectangle renderer: turns the per-frame tracked pen centroid into a stable corner pair (x_out_1/y_out_1, x_out_2/y_out_2) that drives the renderer's x_in_1/y_in_1/x_in_2/y_in_2.
- A corner is committed when the centroid dwells within a tolerance box for HOLD_FRAMES consecutive samples.
- Two corners are captured in order. The pair is then locked until cleared.

---
 rtl/rect_corner_capture.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rect_corner_capture.sv
// rect_corner_capture: turns the per-frame pen centroid into a stable corner
// pair for the rectangle renderer. A corner commits after the centroid dwells
// inside a +/-TOL box for HOLD_FRAMES consecutive samples. Corner 1 is taken
// first, then corner 2, then the pair is locked until clear_in.
// Optional macro RUBBER_BAND_EN: while seeking corner 2, corner 2 outputs
// follow the live centroid as a preview.
module rect_corner_capture #(
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned TOL         = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  input  logic        detect_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic        clear_in,
  output logic [10:0] x_out_1,
  output logic [9:0]  y_out_1,
  output logic [10:0] x_out_2,
  output logic [9:0]  y_out_2,
  output logic        rect_valid_out,
  output logic        capture_out,
  output logic [1:0]  state_out
);

  localparam int unsigned CntW = $clog2(HOLD_FRAMES + 1);
  localparam logic [CntW-1:0] HoldCnt = CntW'(HOLD_FRAMES);
  localparam logic [11:0] TolX = 12'(TOL);
  localparam logic [10:0] TolY = 11'(TOL);

  typedef enum logic [1:0] {
    StSeek1  = 2'd0,
    StSeek2  = 2'd1,
    StLocked = 2'd2
  } state_e;

  state_e          r_state, w_state_d;
  logic [10:0]     r_ax, w_ax_d;
  logic [9:0]      r_ay, w_ay_d;
  logic            r_anchor_vld, w_anchor_vld_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [10:0]     r_x1, w_x1_d, r_x2, w_x2_d;
  logic [9:0]      r_y1, w_y1_d, r_y2, w_y2_d;
  logic            r_capture, w_capture_d;
  logic            r_rect_valid, w_rect_valid_d;

  // Dwell datapath: compare the sample against the current anchor.
  logic [11:0]     w_dx;
  logic [10:0]     w_dy;
  logic            w_in_tol;
  logic [10:0]     w_run_ax;
  logic [9:0]      w_run_ay;
  logic [CntW-1:0] w_run_cnt;
  logic            w_hit;
  logic [11:0]     w_cx;
  logic [10:0]     w_cy;
  logic            w_degen;

  // Unsigned distances with one extra bit so nothing wraps.
  always_comb begin
    w_dx = (x_in >= r_ax) ? ({1'b0, x_in} - {1'b0, r_ax}) : ({1'b0, r_ax} - {1'b0, x_in});
    w_dy = (y_in >= r_ay) ? ({1'b0, y_in} - {1'b0, r_ay}) : ({1'b0, r_ay} - {1'b0, y_in});
    w_in_tol = r_anchor_vld && (w_dx <= TolX) && (w_dy <= TolY);
    // A run that breaks (or starts) re-anchors on this sample.
    w_run_ax  = w_in_tol ? r_ax : x_in;
    w_run_ay  = w_in_tol ? r_ay : y_in;
    w_run_cnt = w_in_tol ? ((r_cnt == HoldCnt) ? r_cnt : r_cnt + CntW'(1)) : CntW'(1);
    w_hit     = detect_in && (w_run_cnt == HoldCnt);
    w_cx = (w_run_ax >= r_x1) ? ({1'b0, w_run_ax} - {1'b0, r_x1})
                              : ({1'b0, r_x1} - {1'b0, w_run_ax});
    w_cy = (w_run_ay >= r_y1) ? ({1'b0, w_run_ay} - {1'b0, r_y1})
                              : ({1'b0, r_y1} - {1'b0, w_run_ay});
    // A corner 2 sharing a row or column band with corner 1 gives a zero-area box.
    w_degen = (w_cx <= TolX) || (w_cy <= TolY);
  end

  // Next-state and output decode; clear_in overrides any sample.
  always_comb begin
    w_state_d      = r_state;
    w_ax_d         = r_ax;
    w_ay_d         = r_ay;
    w_anchor_vld_d = r_anchor_vld;
    w_cnt_d        = r_cnt;
    w_x1_d         = r_x1;
    w_y1_d         = r_y1;
    w_x2_d         = r_x2;
    w_y2_d         = r_y2;
    w_capture_d    = 1'b0;
    w_rect_valid_d = r_rect_valid;

    if (clear_in) begin
      w_state_d      = StSeek1;
      w_ax_d         = '0;
      w_ay_d         = '0;
      w_anchor_vld_d = 1'b0;
      w_cnt_d        = '0;
      w_x1_d         = '0;
      w_y1_d         = '0;
      w_x2_d         = '0;
      w_y2_d         = '0;
      w_rect_valid_d = 1'b0;
    end else if (valid_in && (r_state != StLocked)) begin
      if (!detect_in) begin
        w_anchor_vld_d = 1'b0;
        w_cnt_d        = '0;
`ifdef RUBBER_BAND_EN
        if (r_state == StSeek2) begin
          w_x2_d = r_x1;
          w_y2_d = r_y1;
        end
`endif
      end else begin
        w_ax_d         = w_run_ax;
        w_ay_d         = w_run_ay;
        w_anchor_vld_d = 1'b1;
        w_cnt_d        = w_run_cnt;
`ifdef RUBBER_BAND_EN
        if (r_state == StSeek2) begin
          w_x2_d = x_in;
          w_y2_d = y_in;
        end
`endif
        if (w_hit) begin
          // Any commit attempt ends the run so it cannot be reused.
          w_anchor_vld_d = 1'b0;
          w_cnt_d        = '0;
          if (r_state == StSeek1) begin
            w_x1_d      = w_run_ax;
            w_y1_d      = w_run_ay;
            w_x2_d      = w_run_ax;
            w_y2_d      = w_run_ay;
            w_capture_d = 1'b1;
            w_state_d   = StSeek2;
          end else if (!w_degen) begin
            w_x2_d         = w_run_ax;
            w_y2_d         = w_run_ay;
            w_capture_d    = 1'b1;
            w_state_d      = StLocked;
            w_rect_valid_d = 1'b1;
          end
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= StSeek1;
      r_ax         <= '0;
      r_ay         <= '0;
      r_anchor_vld <= 1'b0;
      r_cnt        <= '0;
      r_x1         <= '0;
      r_y1         <= '0;
      r_x2         <= '0;
      r_y2         <= '0;
      r_capture    <= 1'b0;
      r_rect_valid <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_ax         <= w_ax_d;
      r_ay         <= w_ay_d;
      r_anchor_vld <= w_anchor_vld_d;
      r_cnt        <= w_cnt_d;
      r_x1         <= w_x1_d;
      r_y1         <= w_y1_d;
      r_x2         <= w_x2_d;
      r_y2         <= w_y2_d;
      r_capture    <= w_capture_d;
      r_rect_valid <= w_rect_valid_d;
    end
  end

  assign x_out_1        = r_x1;
  assign y_out_1        = r_y1;
  assign x_out_2        = r_x2;
  assign y_out_2        = r_y2;
  assign rect_valid_out = r_rect_valid;
  assign capture_out    = r_capture;
  assign state_out      = r_state;

endmodule
